// File: rtl/ram_reader.sv
// Burst reader for a RAM16K-style memory: streams count words from base with a valid/ready handshake.
// Optional clear-on-read behaviour is enabled by defining RAM_READER_CLEAR_EN.
module ram_reader #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   count,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  output logic [DATA_W-1:0] ram_in,
  input  logic [DATA_W-1:0] ram_out,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              data_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    VALID = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [ADDR_W:0] REM_ONE = (ADDR_W+1)'(1);

  state_t              state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg, addr_next;
  logic [ADDR_W:0]     remaining_reg, remaining_next;
  logic [DATA_W-1:0]   data_reg, data_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      remaining_reg <= '0;
      data_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      addr_reg      <= addr_next;
      remaining_reg <= remaining_next;
      data_reg      <= data_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    addr_next      = addr_reg;
    remaining_next = remaining_reg;
    data_next      = data_reg;
    case (state_reg)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            addr_next      = base;
            remaining_next = count;
            state_next     = READ;
          end else begin
            state_next = DONE;
          end
        end
      end
      READ: begin
        data_next  = ram_out;
        state_next = VALID;
      end
      VALID: begin
        // Handshake only advances the burst; while stalled every output holds.
        if (data_ready) begin
          if (remaining_reg == REM_ONE) begin
            state_next = DONE;
          end else begin
            addr_next      = addr_reg + 1'b1;
            remaining_next = remaining_reg - REM_ONE;
            state_next     = READ;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign ram_address = addr_reg;
  assign data_out    = data_reg;
  assign data_valid  = (state_reg == VALID);
  assign data_last   = (state_reg == VALID) && (remaining_reg == REM_ONE);
  assign busy        = (state_reg != IDLE);
  assign done        = (state_reg == DONE);

`ifdef RAM_READER_CLEAR_EN
  // The RAM returns the old word combinationally and stores zero at the same edge.
  assign ram_load = (state_reg == READ);
  assign ram_in   = '0;
`else
  assign ram_load = 1'b0;
  assign ram_in   = '0;
`endif

endmodule

// File: tb/tb_ram_reader.sv
// Self-checking bench for ram_reader: behavioural RAM plus an expected-word queue per burst.
module tb_ram_reader;
  localparam int AW = 14;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset, start, data_ready;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic [AW-1:0] ram_address;
  logic          ram_load;
  logic [DW-1:0] ram_in, ram_out, data_out;
  logic          data_valid, data_last, busy, done;

  ram_reader #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .base(base), .count(count),
    .ram_address(ram_address), .ram_load(ram_load), .ram_in(ram_in), .ram_out(ram_out),
    .data_out(data_out), .data_valid(data_valid), .data_ready(data_ready),
    .data_last(data_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // RAM16K model: combinational read, write at the rising edge.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          tb_we;
  logic [AW-1:0] tb_wa;
  logic [DW-1:0] tb_wd;
  assign ram_out = mem[ram_address];
  always @(posedge clk) begin
    if (ram_load) mem[ram_address] <= ram_in;
    else if (tb_we) mem[tb_wa] <= tb_wd;
  end

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [DW-1:0] exp_words[$];
  logic [AW-1:0] last_addr;

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] w);
    tb_we = 1'b1; tb_wa = a; tb_wd = w;
    @(negedge clk);
    tb_we = 1'b0;
    exp_words.push_back(w);
  endtask

  task automatic preload_rand(input logic [AW-1:0] b, input int n);
    exp_words.delete();
    for (int i = 0; i < n; i++) preload(b + AW'(i), DW'($urandom));
  endtask

  // Runs one burst; mode 0 = ready held high, 1 = random ready, 2 = stall 3 cycles on word 2.
  task automatic run_burst(input logic [AW-1:0] b, input int n, input int mode, input bit noise);
    int cyc, idx, hold, budget;
    bit finished, prev_stall, rdy;
    logic [AW-1:0] ea;
    logic [DW-1:0] ew;
    cyc = 1; idx = 0; hold = 0; finished = 0; prev_stall = 0;
    budget = 6 * n + 20;
    start = 1'b1; base = b; count = (AW+1)'(n); data_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (!finished && cyc < budget) begin
`ifndef RAM_READER_CLEAR_EN
      n_cmp++; if (ram_load !== 1'b0) begin n_bad++; $display("FAIL ram_load_tied: got %b expected 0", ram_load); end
`endif
      if (prev_stall) begin
        n_cmp++; if (data_valid !== 1'b1) begin n_bad++; $display("FAIL valid_held: got %b expected 1 (word %0d)", data_valid, idx); end
      end
      prev_stall = 0;
      if (done) begin
        n_cmp++; if (idx !== n) begin n_bad++; $display("FAIL words_before_done: got %0d expected %0d", idx, n); end
        n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL valid_in_done: got %b expected 0", data_valid); end
        if (mode == 0) begin
          n_cmp++; if (cyc !== 2 * n + 1) begin n_bad++; $display("FAIL done_timing: got cycle %0d expected %0d", cyc, 2 * n + 1); end
        end
        finished = 1;
        data_ready = 1'(($urandom_range(0, 1)));
        start = noise;
        base = AW'($urandom); count = (AW+1)'($urandom_range(1, 9));
      end else if (data_valid) begin
        hold++;
        if (idx >= n) begin
          n_cmp++; n_bad++; $display("FAIL extra_word: got word %0d data %0h expected none", idx, data_out);
          data_ready = 1'b1;
        end else begin
          ea = b + AW'(idx);
          ew = exp_words[idx];
          n_cmp++; if (data_out !== ew) begin n_bad++; $display("FAIL data_out[%0d]: got %0h expected %0h", idx, data_out, ew); end
          n_cmp++; if (data_last !== 1'(idx == n - 1)) begin n_bad++; $display("FAIL data_last[%0d]: got %b expected %b", idx, data_last, idx == n - 1); end
          n_cmp++; if (ram_address !== ea) begin n_bad++; $display("FAIL ram_address[%0d]: got %0h expected %0h", idx, ram_address, ea); end
          if (idx == 0 && hold == 1) begin
            n_cmp++; if (cyc !== 2) begin n_bad++; $display("FAIL first_latency: got %0d expected 2", cyc); end
          end
          if (mode == 0) rdy = 1'b1;
          else if (mode == 2) rdy = (idx != 1) || (hold >= 4);
          else rdy = ($urandom_range(0, 2) != 0);
          data_ready = rdy;
          if (rdy) begin
            if (mode == 2 && idx == 1) begin
              n_cmp++; if (hold !== 4) begin n_bad++; $display("FAIL stall_hold: got %0d cycles expected 4", hold); end
            end
            idx++; hold = 0;
          end else begin
            prev_stall = 1;
          end
        end
      end else begin
        n_cmp++; if (data_last !== 1'b0) begin n_bad++; $display("FAIL last_without_valid: got %b expected 0", data_last); end
        n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL busy_mid_burst: got %b expected 1", busy); end
        data_ready = 1'($urandom_range(0, 1));
      end
      if (!finished) begin
        if (noise && busy) begin
          start = 1'($urandom_range(0, 1)); base = AW'($urandom); count = (AW+1)'($urandom_range(0, 30));
        end else begin
          start = 1'b0;
        end
        @(negedge clk);
        cyc++;
      end
    end
    if (!finished) begin
      n_cmp++; n_bad++; $display("FAIL burst_timeout: got no done within %0d cycles expected done", budget);
    end
    @(negedge clk);
    start = 1'b0; data_ready = 1'b0;
    last_addr = b + AW'(n - 1);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL idle_after_done: busy got %b expected 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL done_one_cycle: got %b expected 0", done); end
    n_cmp++; if (ram_address !== last_addr) begin n_bad++; $display("FAIL idle_address: got %0h expected %0h", ram_address, last_addr); end
    for (int i = 0; i < n; i++) begin
      ea = b + AW'(i);
`ifdef RAM_READER_CLEAR_EN
      ew = '0;
`else
      ew = exp_words[i];
`endif
      n_cmp++; if (mem[ea] !== ew) begin n_bad++; $display("FAIL ram_after[%0h]: got %0h expected %0h", ea, mem[ea], ew); end
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; start = 1'b1; base = 14'd100; count = 15'd5; data_ready = 1'b1; tb_we = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b expected 0", data_valid); end
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %b expected 0", done); end
    n_cmp++; if (data_last !== 1'b0) begin n_bad++; $display("FAIL reset_last: got %b expected 0", data_last); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL reset_data: got %0h expected 0", data_out); end
    n_cmp++; if (ram_address !== '0) begin n_bad++; $display("FAIL reset_address: got %0h expected 0", ram_address); end
    n_cmp++; if (ram_load !== 1'b0) begin n_bad++; $display("FAIL reset_load: got %b expected 0", ram_load); end
    reset = 1'b0; start = 1'b0; data_ready = 1'b0;
    last_addr = '0;
    @(negedge clk);
  endtask

  task automatic test_basic;
    exp_words.delete();
    for (int i = 0; i < 4; i++) preload(AW'(5 + i), DW'(16'h0A + i));
    run_burst(14'd5, 4, 0, 1'b0);
  endtask

  task automatic test_stall;
    exp_words.delete();
    for (int i = 0; i < 4; i++) preload(AW'(5 + i), DW'(16'h0A + i));
    run_burst(14'd5, 4, 2, 1'b0);
  endtask

  task automatic test_wrap;
    exp_words.delete();
    preload(14'd16383, 16'hBEEF);
    preload(14'd0, 16'h1234);
    run_burst(14'd16383, 2, 0, 1'b0);
  endtask

  task automatic test_zero_count;
    start = 1'b1; base = AW'($urandom); count = '0;
    @(negedge clk);
    start = 1'b0;
    n_cmp++; if (done !== 1'b1) begin n_bad++; $display("FAIL zero_done: got %b expected 1", done); end
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL zero_busy: got %b expected 1", busy); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL zero_valid: got %b expected 0", data_valid); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0) begin n_bad++; $display("FAIL zero_done_pulse: got %b expected 0", done); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zero_idle: got %b expected 0", busy); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL zero_valid_after: got %b expected 0", data_valid); end
    n_cmp++; if (ram_address !== last_addr) begin n_bad++; $display("FAIL zero_address: got %0h expected %0h", ram_address, last_addr); end
  endtask

  task automatic test_start_ignored;
    logic [AW-1:0] b;
    b = AW'($urandom);
    preload_rand(b, 6);
    run_burst(b, 6, 1, 1'b1);
  endtask

  task automatic test_reset_mid;
    logic [AW-1:0] b;
    int seen;
    bit hit;
    b = AW'($urandom_range(0, 16000));
    preload_rand(b, 4);
    start = 1'b1; base = b; count = 15'd4; data_ready = 1'b1;
    @(negedge clk);
    start = 1'b0; seen = 0; hit = 0;
    for (int c = 0; c < 20 && !hit; c++) begin
      if (data_valid) seen++;
      if (seen == 2) begin
        hit = 1;
        reset = 1'b1; start = 1'b1; base = AW'($urandom); count = 15'd3;
      end
      @(negedge clk);
    end
    n_cmp++; if (!hit) begin n_bad++; $display("FAIL rst_mid_reach: got %0d words expected 2", seen); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    n_cmp++; if (data_valid !== 1'b0) begin n_bad++; $display("FAIL rst_mid_valid: got %b expected 0", data_valid); end
    n_cmp++; if (data_out !== '0) begin n_bad++; $display("FAIL rst_mid_data: got %0h expected 0", data_out); end
    n_cmp++; if (ram_address !== '0) begin n_bad++; $display("FAIL rst_mid_address: got %0h expected 0", ram_address); end
    reset = 1'b0; start = 1'b0; data_ready = 1'b0;
    last_addr = '0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_bad++; $display("FAIL rst_mid_quiet: got done=%b busy=%b expected 0 0", done, busy); end
      @(negedge clk);
    end
    b = AW'($urandom);
    preload_rand(b, 4);
    run_burst(b, 4, 0, 1'b0);
  endtask

  task automatic test_random;
    logic [AW-1:0] b;
    int n;
    for (int t = 0; t < 25; t++) begin
      b = AW'($urandom);
      if ($urandom_range(0, 3) == 0) b = AW'(16383 - $urandom_range(0, 5));
      n = $urandom_range(1, 12);
      preload_rand(b, n);
      run_burst(b, n, $urandom_range(0, 1), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_wrap();
    test_zero_count();
    test_start_ignored();
    test_reset_mid();
    test_zero_count();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
